// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receiver, transmitter and the byte FIFO
// that sits between them.
//   UART_DATA_W           width of one UART data word
//   UART_FIFO_DEPTH_DFLT  default number of FIFO entries
package uart_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int UART_FIFO_DEPTH_DFLT = 16;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x DATA_W register array with one synchronous write port
// and one asynchronous read port. The contents are intentionally not reset;
// the FIFO pointers decide which entries are meaningful.
// Ports:
//   clk    in   clock, write on rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  data stored at raddr (combinational)
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write: one entry per accepted write, no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Zero-latency read so the head entry is always on rdata.
    always_comb begin
        rdata = mem_r[raddr];
    end

endmodule : uart_fifo_mem

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: first-word-fall-through byte FIFO between the UART receiver
// (write side) and the UART transmitter (read side).
// Optional feature macro: UART_FIFO_ERR_EN adds sticky overflow/underflow flags.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous reset, asserted HIGH (historical name kept)
//   w_en         in   write strobe from receiver
//   w_data       in   write data
//   full         out  no free entry
//   almost_full  out  count >= AF_LEVEL
//   read_en      in   pop strobe from transmitter
//   r_data       out  head-of-queue data, valid while empty==0
//   empty        out  no stored entry
//   count        out  occupancy 0..DEPTH
//   err_clr      in   (UART_FIFO_ERR_EN) clear both sticky error flags
//   overflow     out  (UART_FIFO_ERR_EN) sticky: write attempted while full
//   underflow    out  (UART_FIFO_ERR_EN) sticky: read attempted while empty
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W   = UART_DATA_W,
    parameter int DEPTH    = UART_FIFO_DEPTH_DFLT,
    parameter int AF_LEVEL = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   w_en,
    input  logic [DATA_W-1:0]      w_data,
    output logic                   full,
    output logic                   almost_full,
    input  logic                   read_en,
    output logic [DATA_W-1:0]      r_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
`ifdef UART_FIFO_ERR_EN
    ,
    input  logic                   err_clr,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam int              ADDR_W  = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);

    logic [ADDR_W:0] wr_ptr_r;
    logic [ADDR_W:0] rd_ptr_r;
    logic [ADDR_W:0] count_r;
    logic            full_r;
    logic            empty_r;
    logic            af_r;

    logic            wr_acc_s;
    logic            rd_acc_s;
    logic [ADDR_W:0] wr_ptr_nxt_s;
    logic [ADDR_W:0] rd_ptr_nxt_s;
    logic [ADDR_W:0] count_nxt_s;
    logic            full_nxt_s;
    logic            empty_nxt_s;
    logic            af_nxt_s;

    // Acceptance uses the registered flags: a write at full is dropped even if
    // a pop happens on the same edge, and a pop at empty is ignored even if a
    // write lands on the same edge.
    always_comb begin
        wr_acc_s = w_en & ~full_r;
        rd_acc_s = read_en & ~empty_r;
    end

    // Next pointers and the flags derived from them, so the registered flags
    // always match the registered pointers.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (wr_acc_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_acc_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
        full_nxt_s  = (wr_ptr_nxt_s[ADDR_W] != rd_ptr_nxt_s[ADDR_W]) &&
                      (wr_ptr_nxt_s[ADDR_W-1:0] == rd_ptr_nxt_s[ADDR_W-1:0]);
        empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        af_nxt_s    = (count_nxt_s >= AF_C);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_r <= {(ADDR_W + 1){1'b0}};
            rd_ptr_r <= {(ADDR_W + 1){1'b0}};
            count_r  <= {(ADDR_W + 1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            af_r     <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= full_nxt_s;
            empty_r  <= empty_nxt_s;
            af_r     <= af_nxt_s;
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r[ADDR_W-1:0]),
        .wdata (w_data),
        .raddr (rd_ptr_r[ADDR_W-1:0]),
        .rdata (r_data)
    );

    // Drive status outputs from their registers.
    always_comb begin
        count       = count_r;
        full        = full_r;
        empty       = empty_r;
        almost_full = af_r;
    end

`ifdef UART_FIFO_ERR_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags; a clear wins over a set on the same edge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (err_clr) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (w_en && full_r) begin
                overflow_r <= 1'b1;
            end
            if (read_en && empty_r) begin
                underflow_r <= 1'b1;
            end
        end
    end

    // Drive error outputs from their registers.
    always_comb begin
        overflow  = overflow_r;
        underflow = underflow_r;
    end
`endif

endmodule : uart_byte_fifo

// File: tb/tb_uart_byte_fifo.sv
// Self-checking bench for uart_byte_fifo (DEPTH=16, AF_LEVEL=14).
// Expected bytes are queued when the bench issues an accepted write; a monitor
// pops and compares them whenever the DUT performs a pop.
module tb_uart_byte_fifo;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       w_en    = 1'b0;
    logic [7:0] w_data  = 8'h00;
    logic       read_en = 1'b0;
    logic       full;
    logic       almost_full;
    logic [7:0] r_data;
    logic       empty;
    logic [4:0] count;
`ifdef UART_FIFO_ERR_EN
    logic       err_clr = 1'b0;
    logic       overflow;
    logic       underflow;
`endif

    int         total   = 0;
    int         bad     = 0;
    int         mdl_cnt = 0;
    logic       mdl_ovf = 1'b0;
    logic       mdl_udf = 1'b0;
    logic [7:0] exp_q [$];

    uart_byte_fifo dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_en        (w_en),
        .w_data      (w_data),
        .full        (full),
        .almost_full (almost_full),
        .read_en     (read_en),
        .r_data      (r_data),
        .empty       (empty),
        .count       (count)
`ifdef UART_FIFO_ERR_EN
        ,
        .err_clr     (err_clr),
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: apply inputs, check pre-edge state against the
    // model, then advance the model by the edge that consumes these inputs.
    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic clr);
        @(posedge clk);
        #1;
        w_en    = w;
        w_data  = d;
        read_en = r;
`ifdef UART_FIFO_ERR_EN
        err_clr = clr;
`endif
        @(negedge clk);
        chk("count", 32'(count), 32'(mdl_cnt));
        chk("empty", 32'(empty), 32'(mdl_cnt == 0));
        chk("full", 32'(full), 32'(mdl_cnt == 16));
        chk("almost_full", 32'(almost_full), 32'(mdl_cnt >= 14));
`ifdef UART_FIFO_ERR_EN
        chk("overflow", 32'(overflow), 32'(mdl_ovf));
        chk("underflow", 32'(underflow), 32'(mdl_udf));
`endif
        if (clr) begin
            mdl_ovf = 1'b0;
            mdl_udf = 1'b0;
        end else begin
            if (w && mdl_cnt == 16) mdl_ovf = 1'b1;
            if (r && mdl_cnt == 0) mdl_udf = 1'b1;
        end
        begin
            automatic bit wa = w && (mdl_cnt != 16);
            automatic bit ra = r && (mdl_cnt != 0);
            if (wa) exp_q.push_back(d);
            mdl_cnt = mdl_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
        end
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic reads(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Reset pulse: the clear must be visible before the next clock edge.
    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        w_en    = 1'b0;
        read_en = 1'b0;
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        mdl_cnt = 0;
        mdl_ovf = 1'b0;
        mdl_udf = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    // Monitor: every DUT pop is compared with the oldest queued byte.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n == 1'b0 && read_en && !empty) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected actual=%0h required=none", r_data);
                end else begin
                    automatic logic [7:0] e = exp_q.pop_front();
                    if (r_data !== e) begin
                        bad++;
                        $display("FAIL pop_data actual=%0h required=%0h t=%0t", r_data, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle();
        idle();

        // Three bytes in, then out in order.
        drive(1'b1, 8'h41, 1'b0, 1'b0);
        drive(1'b1, 8'h42, 1'b0, 1'b0);
        drive(1'b1, 8'h43, 1'b0, 1'b0);
        idle();
        chk("head_41", 32'(r_data), 32'h41);
        chk("count_3", 32'(count), 32'd3);
        reads(3);
        idle();

        // Fill to full, one dropped write, drain.
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        idle();
        chk("full_16", 32'(full), 32'd1);
        reads(16);
        idle();

        // Simultaneous write+read at full, then at empty.
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        idle();
        chk("count_15", 32'(count), 32'd15);
        reads(15);
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        idle();
        chk("count_1", 32'(count), 32'd1);
        chk("head_aa", 32'(r_data), 32'hAA);
        reads(1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        idle();

        // Steady count=5 with pointer wrap.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
        idle();
        chk("count_5", 32'(count), 32'd5);
        reads(5);
        idle();

        // Reset mid-operation, then normal reuse.
        for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        idle();
        chk("count_9", 32'(count), 32'd9);
        pulse_reset();
        idle();
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        idle();
        chk("head_5a", 32'(r_data), 32'h5A);
        reads(1);
        reads(1);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_byte_fifo
